// File: rtl/ntt_bram_sched_pkg.sv
// Shared definitions for the NTT BRAM scheduler: FSM encoding and width/latency helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package ntt_bram_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Ceiling log2; callers guarantee v >= 2 so the result is never zero-width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Write-back lag: one cycle of registered BRAM read plus the butterfly pipeline.
  function automatic int calc_lat(input int bflat);
    return bflat + 1;
  endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register with synchronous clear (write-back valid+address alignment).
// Latency: exactly DEPTH cycles from din to dout.
// Backpressure: none; advances every cycle.
// Ports: clk, reset (sync, active-high), din[WIDTH], dout[WIDTH].
module ntt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/ntt_bram_sched.sv
// In-place radix-2 NTT scheduler: sequences BRAM reads (a then b), twiddle index and write-backs.
// Latency: first read 1 cycle after start is taken; write-back trails its read by BFLAT+1 cycles.
// Backpressure: none; start is ignored while busy, reset aborts and discards pending writes.
// Ports: clk, reset, start -> busy, done, raddr, rd_valid, rd_first, twaddr, stage, wen, waddr.
module ntt_bram_sched
  import ntt_bram_sched_pkg::*;
#(
  parameter int HLEN  = 9,
  parameter int BFLAT = 8,
  localparam int SW   = clog2(HLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [HLEN-1:0] raddr,
  output logic            rd_valid,
  output logic            rd_first,
  output logic [HLEN-2:0] twaddr,
  output logic [SW-1:0]   stage,
  output logic            wen,
  output logic [HLEN-1:0] waddr
);

  localparam int LAT = calc_lat(BFLAT);
  localparam int DW  = clog2(LAT + 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   stg_q, stg_d;
  logic [HLEN-2:0] j_q, j_d;
  logic            phase_q, phase_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;

  logic [HLEN-1:0] raddr_d;
  logic            rd_valid_d, rd_first_d, busy_d, done_d;
  logic [HLEN-2:0] twaddr_d;

  // Pair address generation for the current (stage, j).
  logic [HLEN-1:0] jw, hbit, mask, addr_a, addr_b;
  logic [HLEN-2:0] tw_v;
  int              sh;

  always_comb begin
    sh     = HLEN - 1 - int'(stg_q);
    jw     = {1'b0, j_q};
    hbit   = HLEN'(1) << sh;          // h = N >> (stage+1)
    mask   = hbit - HLEN'(1);
    // group base (j with offset bits dropped, shifted past the h bit) plus in-group offset
    addr_a = ((jw >> sh) << (sh + 1)) | (jw & mask);
    addr_b = addr_a + hbit;
    tw_v   = (j_q & mask[HLEN-2:0]) << stg_q;
  end

  always_comb begin
    state_d    = state_q;
    stg_d      = stg_q;
    j_d        = j_q;
    phase_d    = phase_q;
    dcnt_d     = dcnt_q;
    raddr_d    = raddr;
    twaddr_d   = twaddr;
    rd_valid_d = 1'b0;
    rd_first_d = 1'b0;
    busy_d     = (state_q == ST_READ) || (state_q == ST_DRAIN);
    done_d     = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          stg_d   = '0;
          j_d     = '0;
          phase_d = 1'b0;
        end
      end
      ST_READ: begin
        rd_valid_d = 1'b1;
        rd_first_d = ~phase_q;
        raddr_d    = phase_q ? addr_b : addr_a;
        twaddr_d   = tw_v;
        phase_d    = ~phase_q;
        if (phase_q) begin
          j_d = j_q + (HLEN-1)'(1);
          if (&j_q) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      ST_DRAIN: begin
        // Hold off the next stage until the last write-back of this one has issued.
        dcnt_d = dcnt_q + DW'(1);
        if (dcnt_q == DW'(LAT - 1)) begin
          if (stg_q == SW'(HLEN - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
            stg_d   = stg_q + SW'(1);
            j_d     = '0;
            phase_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      stg_q    <= '0;
      j_q      <= '0;
      phase_q  <= 1'b0;
      dcnt_q   <= '0;
      raddr    <= '0;
      twaddr   <= '0;
      rd_valid <= 1'b0;
      rd_first <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      stage    <= '0;
    end else begin
      state_q  <= state_d;
      stg_q    <= stg_d;
      j_q      <= j_d;
      phase_q  <= phase_d;
      dcnt_q   <= dcnt_d;
      raddr    <= raddr_d;
      twaddr   <= twaddr_d;
      rd_valid <= rd_valid_d;
      rd_first <= rd_first_d;
      busy     <= busy_d;
      done     <= done_d;
      stage    <= stg_q;
    end
  end

  // Write-back path: {wen, waddr} is {rd_valid, raddr} delayed by LAT cycles.
  logic [HLEN:0] wb_out;

  ntt_delay_line #(
    .WIDTH (HLEN + 1),
    .DEPTH (LAT)
  ) u_wb_dly (
    .clk   (clk),
    .reset (reset),
    .din   ({rd_valid, raddr}),
    .dout  (wb_out)
  );

  assign wen   = wb_out[HLEN];
  assign waddr = wb_out[HLEN-1:0];

endmodule

// File: tb/tb_ntt_bram_sched.sv
module tb_ntt_bram_sched;

  localparam int HLEN  = 4;
  localparam int BFLAT = 3;
  localparam int N     = 16;
  localparam int LAT   = 4;
  localparam int PER   = N + LAT;     // cycles per stage
  localparam int TLEN  = 82;          // start edge to next possible start edge

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, rd_valid, rd_first, wen;
  logic [3:0] raddr, waddr;
  logic [2:0] twaddr;
  logic [1:0] stage;

  ntt_bram_sched #(.HLEN(HLEN), .BFLAT(BFLAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .raddr    (raddr),
    .rd_valid (rd_valid),
    .rd_first (rd_first),
    .twaddr   (twaddr),
    .stage    (stage),
    .wen      (wen),
    .waddr    (waddr)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Expected per-cycle trace of one transform, cycle 0 = edge where start is taken.
  int m_rv [200], m_ra [200], m_rf [200], m_tw [200], m_stg [200];
  int m_we [200], m_wa [200], m_busy [200], m_done [200];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},   32'(busy),     0);
    chk({tag, "_done"},   32'(done),     0);
    chk({tag, "_rv"},     32'(rd_valid), 0);
    chk({tag, "_rf"},     32'(rd_first), 0);
    chk({tag, "_wen"},    32'(wen),      0);
    chk({tag, "_raddr"},  32'(raddr),    0);
    chk({tag, "_waddr"},  32'(waddr),    0);
    chk({tag, "_twaddr"}, 32'(twaddr),   0);
    chk({tag, "_stage"},  32'(stage),    0);
  endtask

  task automatic chk_trace(input int c, input int i);
    chk($sformatf("rv@%0d", c),   32'(rd_valid), m_rv[i]);
    chk($sformatf("rf@%0d", c),   32'(rd_first), m_rf[i]);
    chk($sformatf("wen@%0d", c),  32'(wen),      m_we[i]);
    chk($sformatf("busy@%0d", c), 32'(busy),     m_busy[i]);
    chk($sformatf("done@%0d", c), 32'(done),     m_done[i]);
    if (m_rv[i] != 0) begin
      chk($sformatf("raddr@%0d", c),  32'(raddr),  m_ra[i]);
      chk($sformatf("twaddr@%0d", c), 32'(twaddr), m_tw[i]);
      chk($sformatf("stage@%0d", c),  32'(stage),  m_stg[i]);
    end
    if (m_we[i] != 0) chk($sformatf("waddr@%0d", c), 32'(waddr), m_wa[i]);
  endtask

  initial begin
    int len, p, cyc, wcount;

    // Reference model: textbook Cooley-Tukey loop nest (groups, then offsets).
    for (int s = 0; s < HLEN; s++) begin
      len = N >> (s + 1);
      p = 0;
      for (int st = 0; st < N; st += 2 * len) begin
        for (int off = 0; off < len; off++) begin
          cyc = 1 + s * PER + 2 * p;
          m_rv[cyc] = 1;   m_ra[cyc] = st + off;         m_rf[cyc] = 1;
          m_tw[cyc] = off << s;                          m_stg[cyc] = s;
          m_rv[cyc+1] = 1; m_ra[cyc+1] = st + off + len; m_rf[cyc+1] = 0;
          m_tw[cyc+1] = off << s;                        m_stg[cyc+1] = s;
          m_we[cyc+LAT] = 1;   m_wa[cyc+LAT] = st + off;
          m_we[cyc+LAT+1] = 1; m_wa[cyc+LAT+1] = st + off + len;
          p++;
        end
      end
    end
    for (int c = 1; c <= 80; c++) m_busy[c] = 1;
    m_done[81] = 1;

    // ---- reset state ----
    reset = 1'b1;
    start = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    chk_reset_vals("rst");
    step();
    chk_reset_vals("idle");

    // ---- start together with reset is ignored ----
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    step(); step();
    chk("rst_start_busy", 32'(busy), 0);
    chk("rst_start_rv",   32'(rd_valid), 0);

    // ---- two back-to-back transforms, with a stray start mid-transform ----
    start = 1'b1;
    step();                        // edge 0
    start = 1'b0;
    wcount = 0;
    for (int c = 0; c < TLEN + 86; c++) begin
      if (c > 0) step();
      chk_trace(c, (c < TLEN) ? c : c - TLEN);
      if (c < TLEN && wen === 1'b1) wcount++;
      // hand-computed spot values
      if (c == 1)  chk("basic_ra0", 32'(raddr), 0);
      if (c == 2)  chk("basic_ra1", 32'(raddr), 8);
      if (c == 3)  chk("basic_ra2", 32'(raddr), 1);
      if (c == 4)  chk("basic_ra3", 32'(raddr), 9);
      if (c == 3)  chk("basic_tw1", 32'(twaddr), 1);
      if (c == 5)  chk("basic_wa0", 32'({wen, waddr}), 32'h10);
      if (c == 24) chk("s1_b1", 32'(raddr), 5);
      if (c == 23) chk("s1_tw1", 32'(twaddr), 2);
      if (c == 63) chk("s3_a1", 32'(raddr), 2);
      if (c == 63) chk("s3_tw1", 32'(twaddr), 0);
      if (c == 61) chk("s3_stage", 32'(stage), 3);
      if (c == 80) chk("busy_pre_done", 32'(busy), 1);
      if (c == 81) chk("done_81", 32'({busy, done}), 32'h1);
      if (c == TLEN + 1) chk("b2b_ra0", 32'(raddr), 0);
      if (c == TLEN + 81) chk("b2b_done", 32'(done), 1);
      // stimulus
      start = (c == 19) || (c == 81);   // sampled at edges 20 (busy) and 82 (back-to-back)
    end
    chk("wen_count", 32'(wcount), HLEN * N);

    // ---- reset mid-transform ----
    start = 1'b1;
    step();                        // edge 0
    start = 1'b0;
    for (int c = 1; c < 30; c++) begin
      step();
      if (c == 29) reset = 1'b1;   // sampled at edge 30
    end
    step();
    reset = 1'b0;
    chk_reset_vals("midrst");
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("midrst_wen%0d", c), 32'(wen), 0);
      chk($sformatf("midrst_rv%0d", c),  32'(rd_valid), 0);
    end

    // ---- fresh start after abort reproduces the opening sequence ----
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step();
      chk_trace(c, c);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
